// File: rtl/otter_pkg.sv
// otter_pkg: shared RV32I opcode/immediate types and the canonical NOP.
package otter_pkg;
  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_t;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic imm_type_t imm_type(input logic [6:0] op);
    return (op == OPC_OP_IMM || op == OPC_LOAD || op == OPC_JALR) ? IMM_I :
           op == OPC_STORE ? IMM_S :
           op == OPC_BRANCH ? IMM_B :
           (op == OPC_LUI || op == OPC_AUIPC) ? IMM_U :
           op == OPC_JAL ? IMM_J : IMM_NONE;
  endfunction
endpackage

// File: rtl/otter_imm_gen.sv
// otter_imm_gen: combinational RV32I immediate decode, sign-extended to XLEN.
module otter_imm_gen import otter_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ir_i,
  output logic [XLEN-1:0] imm_o
);
  imm_type_t t;
  logic [31:0] imm;
  always_comb begin
    t = imm_type(ir_i[6:0]);
    imm = t == IMM_I ? {{20{ir_i[31]}}, ir_i[31:20]} :
          t == IMM_S ? {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]} :
          t == IMM_B ? {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0} :
          t == IMM_U ? {ir_i[31:12], 12'b0} :
          t == IMM_J ? {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0} : 32'b0;
    imm_o = XLEN'($signed(imm));
  end
endmodule

// File: rtl/otter_decode_stage.sv
// otter_decode_stage: RV32I decode, load-use hazard detection and the ID/EX register.
module otter_decode_stage import otter_pkg::*; #(
  parameter int          XLEN   = 32,
  parameter logic [31:0] NOP_IR = NOP
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_ir,
  output logic [4:0]      rf_read1,
  output logic [4:0]      rf_read2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            flush,
  output logic            stall_if,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [31:0]     ex_ir,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite
);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [31:0]     ir;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
  } idex_t;
  localparam idex_t BUBBLE = idex_t'{ir: NOP_IR, default: '0};
  idex_t idex_d, idex_q;
  logic [6:0] op;
  logic [XLEN-1:0] imm;
  logic rs1_used, rs2_used, rd_wr, hz;
  otter_imm_gen #(.XLEN(XLEN)) u_imm_gen (.ir_i(id_ir), .imm_o(imm));
  assign rf_read1 = id_ir[19:15];
  assign rf_read2 = id_ir[24:20];
  // Bubbles (flush, hazard, empty IF/ID) all load the same cleared NOP slot.
  always_comb begin
    op = id_ir[6:0];
    rs1_used = !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
    rs2_used = op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH;
    rd_wr = !(op == OPC_STORE || op == OPC_BRANCH) && id_ir[11:7] != 5'd0;
    hz = idex_q.valid && idex_q.memread && idex_q.rd != 5'd0 && id_valid &&
         ((rs1_used && id_ir[19:15] == idex_q.rd) || (rs2_used && id_ir[24:20] == idex_q.rd));
    stall_if = hz && !flush;
    idex_d = (flush || hz || !id_valid) ? BUBBLE : idex_t'{
      valid: 1'b1, pc: id_pc, rs1_val: rf_data1, rs2_val: rf_data2, imm: imm, ir: id_ir,
      rs1: id_ir[19:15], rs2: id_ir[24:20], rd: id_ir[11:7], regwrite: rd_wr,
      memread: op == OPC_LOAD, memwrite: op == OPC_STORE};
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) idex_q <= BUBBLE;
    else idex_q <= idex_d;
  assign ex_valid    = idex_q.valid;
  assign ex_pc       = idex_q.pc;
  assign ex_rs1_val  = idex_q.rs1_val;
  assign ex_rs2_val  = idex_q.rs2_val;
  assign ex_imm      = idex_q.imm;
  assign ex_ir       = idex_q.ir;
  assign ex_rs1      = idex_q.rs1;
  assign ex_rs2      = idex_q.rs2;
  assign ex_rd       = idex_q.rd;
  assign ex_regwrite = idex_q.regwrite;
  assign ex_memread  = idex_q.memread;
  assign ex_memwrite = idex_q.memwrite;
endmodule

// File: tb/tb_otter_decode_stage.sv
// tb_otter_decode_stage: directed scoreboard bench for the OTTER decode stage.
module tb_otter_decode_stage;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] ir;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic id_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic [31:0] id_ir = 32'h13;
  logic flush = 1'b0;
  logic [4:0] rf_read1, rf_read2;
  logic [31:0] rf_data1, rf_data2;
  logic stall_if, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_ir;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  exp_t sb[$];
  int errors = 0;
  int total = 0;
  localparam exp_t BUB = exp_t'{ir: 32'h0000_0013, default: '0};
  localparam logic [31:0] LW6 = 32'h0002A303;
  localparam logic [31:0] ADD7 = 32'h005303B3;
  // Register file stand-in: xN reads N*0x100, so x0 reads 0.
  assign rf_data1 = {19'b0, rf_read1, 8'b0};
  assign rf_data2 = {19'b0, rf_read2, 8'b0};
  always #5 clk = ~clk;
  otter_decode_stage dut (
    .clock(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_ir(id_ir),
    .rf_read1(rf_read1), .rf_read2(rf_read2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .flush(flush), .stall_if(stall_if), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_ir(ex_ir),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite));
  function automatic exp_t cap(input logic [31:0] pc, ir, imm, input logic rw, mr, mw);
    return exp_t'{valid: 1'b1, pc: pc, v1: {19'b0, ir[19:15], 8'b0}, v2: {19'b0, ir[24:20], 8'b0},
                  imm: imm, ir: ir, rs1: ir[19:15], rs2: ir[24:20], rd: ir[11:7], rw: rw, mr: mr, mw: mw};
  endfunction
  function automatic exp_t obs();
    return exp_t'{ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_ir,
                  ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_memwrite};
  endfunction
  task automatic check(input string tag, input logic [199:0] o, e);
    total++;
    assert (o === e) else begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, o, e);
      $error("check %s", tag);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] pc, ir, input logic fl, st, input exp_t e, input string tag);
    @(negedge clk);
    id_valid = v;
    id_pc = pc;
    id_ir = ir;
    flush = fl;
    #1;
    check({tag, "_stall"}, 200'(stall_if), 200'(st));
    check({tag, "_rfaddr"}, 200'({rf_read1, rf_read2}), 200'({ir[19:15], ir[24:20]}));
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(tag, 200'(obs()), 200'(sb.pop_front()));
  endtask
  initial begin
    #1 reset = 1'b1;
    #2;
    check("reset_state", 200'(obs()), 200'(BUB));
    check("reset_stall", 200'(stall_if), 200'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    step(1, 32'h100, 32'h00700293, 0, 0, cap(32'h100, 32'h00700293, 32'd7, 1, 0, 0), "addi");
    step(1, 32'h104, LW6, 0, 0, cap(32'h104, LW6, 32'd0, 1, 1, 0), "lw");
    step(1, 32'h108, ADD7, 0, 1, BUB, "add_stall");
    step(1, 32'h108, ADD7, 0, 0, cap(32'h108, ADD7, 32'd0, 1, 0, 0), "add_go");
    step(1, 32'h10C, LW6, 0, 0, cap(32'h10C, LW6, 32'd0, 1, 1, 0), "lw2");
    step(1, 32'h110, ADD7, 1, 0, BUB, "flush_hz");
    step(1, 32'h110, ADD7, 0, 0, cap(32'h110, ADD7, 32'd0, 1, 0, 0), "post_flush");
    step(1, 32'h114, LW6, 0, 0, cap(32'h114, LW6, 32'd0, 1, 1, 0), "lw3");
    step(0, 32'h118, ADD7, 0, 0, BUB, "invalid_id");
    step(1, 32'h200, 32'hFE000CE3, 0, 0, cap(32'h200, 32'hFE000CE3, 32'hFFFFFFF8, 0, 0, 0), "beq");
    step(1, 32'h204, 32'h123450B7, 0, 0, cap(32'h204, 32'h123450B7, 32'h12345000, 1, 0, 0), "lui");
    step(1, 32'h208, 32'h7E20AFA3, 0, 0, cap(32'h208, 32'h7E20AFA3, 32'h000007FF, 0, 0, 1), "sw");
    step(1, 32'h20C, 32'h0002A003, 0, 0, cap(32'h20C, 32'h0002A003, 32'd0, 0, 1, 0), "lw_x0");
    step(1, 32'h210, 32'h000003B3, 0, 0, cap(32'h210, 32'h000003B3, 32'd0, 1, 0, 0), "add_x0");
    step(1, 32'h300, LW6, 0, 0, cap(32'h300, LW6, 32'd0, 1, 1, 0), "lw4");
    @(negedge clk);
    id_ir = ADD7;
    id_pc = 32'h304;
    #1;
    check("mid_stall", 200'(stall_if), 200'(1'b1));
    reset = 1'b1;
    #1;
    check("mid_reset_state", 200'(obs()), 200'(BUB));
    check("mid_reset_stall", 200'(stall_if), 200'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end
endmodule

// File: doc/otter_decode_stage.md
# otter_decode_stage

Instruction-decode stage of the pipelined OTTER RV32I core. It sits between the IF/ID register and the execute stage. It drives the register file's read addresses and captures the returned operands, generates the sign-extended immediate, and detects load-use hazards. It registers everything the execute stage needs into the ID/EX pipeline register, with stall, bubble and flush control.

## Interface
Parameters:
- XLEN, 32, datapath width
- NOP_IR, 32'h0000_0013, instruction word loaded on bubble/flush (ADDI x0,x0,0)

Ports:
- clock  in  1  pipeline clock; ID/EX captures on posedge
- reset  in  1  asynchronous, active-high; clears ID/EX
- id_valid  in  1  IF/ID holds a real instruction
- id_pc  in  XLEN  PC of decoding instruction
- id_ir  in  32  instruction word
- rf_read1 / rf_read2  out  5  combinational rs1/rs2 addresses to register file
- rf_data1 / rf_data2  in  XLEN  operands returned by register file (x0 reads 0)
- flush  in  1  branch/jump resolved taken in EX; kill instruction in ID
- stall_if  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN  registered operands
- ex_ir  out  32  registered instruction
- ex_rs1, ex_rs2, ex_rd  out  5  registered register numbers (for forwarding)
- ex_regwrite, ex_memread, ex_memwrite  out  1  registered control

## Operation
- rf_read1 = id_ir[19:15], rf_read2 = id_ir[24:20], unconditionally.
- Usage flags come from the opcode:
  - rs1 used: all except LUI, AUIPC, JAL.
  - rs2 used: R-type, STORE, BRANCH.
  - rd written: all except STORE, BRANCH, with rd != 0.
- Immediates by opcode:
  - I (OP-IMM, LOAD, JALR): sext(ir[31:20]).
  - S: sext({ir[31:25], ir[11:7]}).
  - B: sext({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}).
  - U: {ir[31:12], 12'b0}.
  - J: sext({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}).
  - Other opcodes: 0.
- Load-use hazard (`hz`) is asserted when all of the following hold:
  - ex_valid && ex_memread && ex_rd != 0 && id_valid;
  - and either (rs1 used && rs1 == ex_rd) or (rs2 used && rs2 == ex_rd).
- Next-state priority, evaluated each cycle:
  1. reset
  2. flush: ex_valid←0, ex_ir←NOP_IR, all controls←0
  3. hz: same bubble; stall_if=1
  4. else: capture ID contents; ex_valid←id_valid
- stall_if = hz && !flush. When flush and a hazard coincide, the flush wins and fetch is not held.
- With ex_valid=0, ex_regwrite, ex_memread and ex_memwrite are always 0.
- No write-back bypass. The register file writes on negedge, so same-cycle reads already see the written value.

## Timing
- Reset: all ex_* outputs 0 except ex_ir=NOP_IR. stall_if is 0 while reset is asserted.
- Latency: 1 cycle from IF/ID to ID/EX.
- A load-use stall lasts exactly 1 cycle. The next cycle ex_valid=0, so hz deasserts, and the held instruction then advances with the correct operand via EX forwarding.
- An id_valid=0 input yields a bubble, never a stall.
- Reset asserted mid-stall clears ID/EX immediately, without waiting for a clock edge.

## Structure
- Shared package otter_pkg holds:
  - opcode_t enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP);
  - imm_type_t;
  - NOP constant.
- Sub-module otter_imm_gen (combinational ir → imm) is instantiated once. The hazard logic and the ID/EX register stay in this module.

## Test plan
- Reset mid-operation: assert reset with valid state in ID/EX -> every ex_* output is 0 immediately, ex_ir=0x00000013, stall_if=0.
- ADDI passthrough: id_ir=0x00700293 (ADDI x5,x0,7), id_pc=0x100 -> rf_read1=0; next cycle ex_imm=7, ex_rd=5, ex_regwrite=1, ex_pc=0x100.
- Load-use stall:
  - Present LW x6,0(x5) (0x0002A303).
  - Next cycle present ADD x7,x6,x5 (0x005303B3) -> stall_if=1 for one cycle and ex_valid=0 on the following edge.
  - Then ADD is captured with ex_rs1=6, ex_rs2=5.
- Flush with hazard: repeat the load-use case with flush=1 in the hazard cycle -> stall_if=0, ex_valid=0, no stall on the following cycle.
- Immediates:
  - BEQ with offset −8 (0xFE000CE3) -> ex_imm=0xFFFFFFF8.
  - LUI 0x12345 -> ex_imm=0x12345000.
  - SW offset 0x7FF -> ex_imm=0x000007FF.
- x0 destination: LW x0 followed by ADD using x0 -> no stall, and ex_regwrite=0 for the load.
